// File: rtl/fir_mac_param.sv
// Sequential-MAC FIR filter: a single multiplier is time-shared over TAPS cycles per sample.
// Runtime-writable signed coefficients, round-half-up with saturation, valid/ready input.
module fir_mac_param #(
    parameter int DATA_W    = 12,
    parameter int COEF_W    = 12,
    parameter int TAPS      = 16,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 11,
    parameter int SIGNED_IN = 0,
    localparam int AW       = $clog2(TAPS),
    localparam int ACC_W    = DATA_W + 1 + COEF_W + AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_err,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    output logic              out_sat,
    output logic              busy
);
    localparam int PW = DATA_W + 1 + COEF_W;
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'((64'd1 << SHIFT) >> 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t state_q, state_d;

    logic signed [DATA_W:0]   x [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [AW-1:0]            k;
    logic signed [ACC_W-1:0]  acc, rnd_sum, r;
    logic signed [PW-1:0]     prod;
    logic signed [DATA_W:0]   x_new;
    logic                     accept, coef_ok, hi, lo;

    // The reset term keeps in_ready low while the block is held in reset.
    assign in_ready = rst & (state_q == S_IDLE) & en & ~clr;
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != S_IDLE);
    assign coef_ok  = coef_we & (state_q == S_IDLE) & ~clr & ({1'b0, coef_addr} < (AW + 1)'(TAPS));

    assign x_new   = (SIGNED_IN != 0) ? {data_in[DATA_W-1], data_in} : {1'b0, data_in};
    assign prod    = PW'(x[k]) * PW'(coef[k]);
    assign rnd_sum = acc + RND;
    assign r       = rnd_sum >>> SHIFT;
    assign hi      = (r > MAXV);
    assign lo      = (r < MINV);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_MAC;
            S_MAC:   if (k == AW'(TAPS - 1)) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clr) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            acc       <= '0;
            k         <= '0;
            coef_err  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            coef_err  <= coef_we & ~coef_ok;
            if (clr) begin
                for (int i = 0; i < TAPS; i++) x[i] <= '0;
                acc <= '0;
                k   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (accept) begin
                        x[0] <= x_new;
                        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
                        acc <= '0;
                        k   <= '0;
                    end
                    S_MAC: begin
                        acc <= acc + ACC_W'(prod);
                        k   <= k + 1'b1;
                    end
                    S_OUT: begin
                        out_valid <= 1'b1;
                        out_sat   <= hi | lo;
                        out_data  <= hi ? MAXV[OUT_W-1:0] : (lo ? MINV[OUT_W-1:0] : r[OUT_W-1:0]);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_param.sv
// Bench for fir_mac_param: three configurations share one stimulus stream and are each
// compared every cycle against a transaction-level model; directed checks cover the corner cases.
module tb_fir_mac_param;
    localparam int NI = 3;

    logic        clk, rst, en, clr, in_valid, coef_we;
    logic [11:0] data_in, coef_data;
    logic [3:0]  coef_addr;
    logic        in_ready [NI];
    logic        coef_err [NI];
    logic        out_valid[NI];
    logic        out_sat  [NI];
    logic        busy     [NI];
    logic [15:0] out_data [NI];

    // Per-instance configuration, mirrored in the parameter overrides below.
    int m_taps [NI] = '{16, 16, 10};
    int m_shift[NI] = '{0, 1, 11};
    bit m_sgn  [NI] = '{1'b1, 1'b0, 1'b0};

    fir_mac_param #(.TAPS(16), .SHIFT(0), .SIGNED_IN(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready[0]), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_sat(out_sat[0]), .busy(busy[0]));
    fir_mac_param #(.TAPS(16), .SHIFT(1), .SIGNED_IN(0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready[1]), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_sat(out_sat[1]), .busy(busy[1]));
    fir_mac_param #(.TAPS(10), .SHIFT(11), .SIGNED_IN(0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready[2]), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
        .out_sat(out_sat[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: sample history and coefficients per instance, plus cycles left until the result.
    longint mx[NI][16];
    longint mc[NI][16];
    int     mcnt[NI];
    longint p_data[NI], e_data[NI];
    bit     p_sat[NI], e_sat[NI], e_valid[NI], e_err[NI];

    longint q0[$], q1[$];
    bit     qs0[$], qs1[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 16; j++) begin mx[i][j] = 0; mc[i][j] = 0; end
            mcnt[i] = 0; p_data[i] = 0; e_data[i] = 0;
            p_sat[i] = 0; e_sat[i] = 0; e_valid[i] = 0; e_err[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit idle;
            idle = (mcnt[i] == 0);
            e_valid[i] = 0;
            e_err[i]   = 0;
            if (coef_we) begin
                if (idle && !clr && int'(coef_addr) < m_taps[i])
                    mc[i][coef_addr] = longint'($signed(coef_data));
                else
                    e_err[i] = 1;
            end
            if (clr) begin
                mcnt[i] = 0;
                for (int j = 0; j < 16; j++) mx[i][j] = 0;
            end else if (!idle) begin
                mcnt[i]--;
                if (mcnt[i] == 0) begin
                    e_valid[i] = 1; e_data[i] = p_data[i]; e_sat[i] = p_sat[i];
                end
            end else if (in_valid && en) begin
                longint acc, rr;
                for (int j = 15; j > 0; j--) mx[i][j] = mx[i][j-1];
                mx[i][0] = m_sgn[i] ? longint'($signed(data_in)) : longint'(data_in);
                acc = 0;
                for (int j = 0; j < m_taps[i]; j++) acc += mc[i][j] * mx[i][j];
                rr = (acc + ((64'sd1 << m_shift[i]) >>> 1)) >>> m_shift[i];
                p_sat[i] = (rr > 32767) || (rr < -32768);
                p_data[i] = (rr > 32767) ? 32767 : ((rr < -32768) ? -32768 : rr);
                mcnt[i] = m_taps[i] + 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("valid%0d", i), out_valid[i], e_valid[i]);
            chk($sformatf("err%0d", i),   coef_err[i],  e_err[i]);
            chk($sformatf("busy%0d", i),  busy[i],      rst && mcnt[i] != 0);
            chk($sformatf("ready%0d", i), in_ready[i],  rst && mcnt[i] == 0 && en && !clr);
            chk($sformatf("data%0d", i),  longint'($signed(out_data[i])), e_data[i]);
            chk($sformatf("sat%0d", i),   out_sat[i],   e_sat[i]);
        end
        if (out_valid[0]) begin q0.push_back(longint'($signed(out_data[0]))); qs0.push_back(out_sat[0]); end
        if (out_valid[1]) begin q1.push_back(longint'($signed(out_data[1]))); qs1.push_back(out_sat[1]); end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_coef(input int a, input logic [11:0] v);
        coef_we = 1; coef_addr = 4'(a); coef_data = v;
        tick();
        coef_we = 0;
    endtask

    task automatic send(input logic [11:0] d);
        in_valid = 1; data_in = d;
        tick();
        in_valid = 0;
        repeat (18) tick();
    endtask

    task automatic pulse_clr();
        clr = 1; tick(); clr = 0;
    endtask

    initial begin
        int aq[$], oq[$];
        int sz;
        rst = 0; en = 1; clr = 0; in_valid = 0; coef_we = 0;
        data_in = '0; coef_addr = '0; coef_data = '0;
        model_reset();
        #1 check_all();
        @(negedge clk) rst = 1;
        tick();

        // Impulse response walks out the coefficients 1..16, then zero.
        for (int k = 0; k < 16; k++) set_coef(k, 12'(k + 1));
        q0.delete(); qs0.delete();
        send(12'd1);
        for (int k = 0; k < 16; k++) send(12'd0);
        chk("imp_cnt", q0.size(), 17);
        for (int k = 0; k < 17 && k < q0.size(); k++) begin
            chk($sformatf("imp_y%0d", k), q0[k], (k < 16) ? k + 1 : 0);
            chk($sformatf("imp_s%0d", k), qs0[k], 0);
        end

        // Back-to-back inputs: accept spacing and output latency.
        for (int k = 0; k < 16; k++) set_coef(k, 12'd1);
        in_valid = 1;
        for (int t = 0; t < 60; t++) begin
            data_in = 12'($urandom);
            if (in_ready[0]) aq.push_back(t);
            tick();
            if (out_valid[0]) oq.push_back(t);
        end
        in_valid = 0;
        repeat (20) tick();
        chk("lat_n", (aq.size() >= 3 && oq.size() >= 3), 1);
        for (int j = 0; j + 1 < aq.size() && j + 1 < oq.size(); j++) begin
            chk("lat_out", oq[j] - aq[j], 17);
            chk("lat_gap", aq[j+1] - aq[j], 18);
        end

        // Saturation at both rails on the signed-input instance.
        for (int k = 0; k < 16; k++) set_coef(k, 12'd2047);
        pulse_clr();
        send(12'd2047);
        chk("sat_hi", q0[$], 32767);
        chk("sat_hi_f", qs0[$], 1);
        pulse_clr();
        send(12'h800);
        chk("sat_lo", q0[$], -32768);
        chk("sat_lo_f", qs0[$], 1);

        // Round half up on the SHIFT=1 instance; negative via a negative coefficient.
        pulse_clr();
        for (int k = 0; k < 16; k++) set_coef(k, (k == 0) ? 12'd1 : 12'd0);
        send(12'd3);
        chk("rnd_3", q1[$], 2);
        send(12'd2);
        chk("rnd_2", q1[$], 1);
        set_coef(0, 12'hFFF);
        send(12'd3);
        chk("rnd_m3", q1[$], -1);
        chk("rnd_sat", qs1[$], 0);

        // Dropped coefficient writes: while busy, out of range, and under clr.
        for (int k = 0; k < 16; k++) set_coef(k, 12'(k + 1));
        pulse_clr();
        in_valid = 1; data_in = 12'd1;
        tick();
        in_valid = 0;
        repeat (3) tick();
        coef_we = 1; coef_addr = 4'd3; coef_data = 12'd99;
        tick();
        chk("err_busy", coef_err[0], 1);
        coef_we = 0;
        repeat (18) tick();
        coef_we = 1; coef_addr = 4'd12; coef_data = 12'd55;
        tick();
        chk("err_range", coef_err[2], 1);
        chk("err_ok", coef_err[0], 0);
        coef_we = 1; coef_addr = 4'd2; coef_data = 12'd77; clr = 1;
        tick();
        chk("err_clr", coef_err[0], 1);
        coef_we = 0; clr = 0;
        pulse_clr();
        send(12'd1);
        for (int k = 0; k < 3; k++) send(12'd0);
        chk("keep_c2", q0[$-1], 3);
        chk("keep_c3", q0[$], 4);

        // Abort with clr in the middle of a MAC.
        in_valid = 1; data_in = 12'd5;
        tick();
        in_valid = 0;
        repeat (5) tick();
        sz = q0.size();
        pulse_clr();
        #1 chk("clr_ready", in_ready[0], 1);
        repeat (20) tick();
        chk("clr_noout", q0.size(), sz);
        send(12'd1);
        chk("clr_imp0", q0[$], 1);
        send(12'd0);
        chk("clr_imp1", q0[$], 2);

        // Asynchronous reset in the middle of a MAC.
        in_valid = 1; data_in = 12'd1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        #2 rst = 0;
        model_reset();
        #1;
        chk("rst_data", out_data[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_ready", in_ready[0], 0);
        chk("rst_valid", out_valid[0], 0);
        check_all();
        @(negedge clk) rst = 1;
        repeat (20) tick();
        send(12'd7);
        chk("rst_coef", q0[$], 0);

        // Random traffic against the model.
        for (int t = 0; t < 1500; t++) begin
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1);
            data_in   = 12'($urandom);
            coef_we   = ($urandom_range(0, 4) == 0);
            coef_addr = 4'($urandom);
            coef_data = 12'($urandom);
            clr       = ($urandom_range(0, 49) == 0);
            tick();
        end
        en = 1; in_valid = 0; coef_we = 0; clr = 0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
